// File: rtl/obi_wb_pkg.sv
// Shared types and helpers for the OBI-to-Wishbone responder.
package obi_wb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_RMW_RD,
      ST_WR,
      ST_RMW_WR,
      ST_RESP
   } state_t;

   localparam logic [3:0] OBI_BE_FULL = 4'hF;

   // Byte-lane merge: enabled lanes come from the OBI write data, the rest
   // keep what the bus returned during the read phase of an RMW.
   function automatic logic [31:0] be_merge(input logic [31:0] wdata,
                                            input logic [31:0] rdata,
                                            input logic [3:0]  be);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/obi_wb_responder.sv
// OBI responder driving Wishbone-classic cycles. One request outstanding;
// partial-byte writes become read-modify-write; a bus timeout forces completion.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | grant follows req, latch request on handshake
// ST_RD     | Wishbone read for an OBI read
// ST_RMW_RD | Wishbone read for a partial write, merge lanes on ack
// ST_WR     | Wishbone write of a full-word OBI write
// ST_RMW_WR | Wishbone write of the merged word (cyc low on first cycle)
// ST_RESP   | one-cycle rvalid pulse back to the core
module obi_wb_responder
   import obi_wb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_addr_o,
   output logic [31:0] wb_data_o,
   input  logic [31:0] wb_data_i,
   input  logic        wb_ack_i
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_inc;
   logic [3:0]       be_q;
   logic             ack, expire, bus_state, cyc_nxt, we_nxt;
   logic             addr_lsb_unused;

   // Word-aligned bus: the byte offset of the OBI address is not needed.
   assign addr_lsb_unused = ^addr_i[1:0];

   // Next-state decode, grant, timeout detection and next bus-control values.
   always_comb begin
      state_nxt = state;
      gnt_o     = 1'b0;
      bus_state = state inside {ST_RD, ST_RMW_RD, ST_WR, ST_RMW_WR};
      ack       = wb_ack_i & wb_cyc_o;
      cnt_inc   = cnt + CNT_W'(1);
      expire    = (TIMEOUT_CYCLES != 0) && bus_state && !ack && (cnt_inc == CNT_LIM);
      case (state)
         ST_IDLE: begin
            gnt_o = req_i & ~rst;
            if (gnt_o) begin
               if (!we_i)                   state_nxt = ST_RD;
               else if (be_i == OBI_BE_FULL) state_nxt = ST_WR;
               else if (be_i == 4'h0)        state_nxt = ST_RESP;
               else                          state_nxt = ST_RMW_RD;
            end
         end
         ST_RD: begin
            if (ack || expire) state_nxt = ST_RESP;
         end
         ST_RMW_RD: begin
            if (ack)         state_nxt = ST_RMW_WR;
            else if (expire) state_nxt = ST_RESP;
         end
         ST_WR, ST_RMW_WR: begin
            if (ack || expire) state_nxt = ST_RESP;
         end
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      cyc_nxt = (state_nxt inside {ST_RD, ST_RMW_RD, ST_WR}) ||
                (state == ST_RMW_WR && state_nxt == ST_RMW_WR);
      we_nxt  = cyc_nxt && (state_nxt inside {ST_WR, ST_RMW_WR});
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Registered bus/response outputs, request buffers and timeout counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         be_q      <= '0;
         wb_cyc_o  <= 1'b0;
         wb_stb_o  <= 1'b0;
         wb_we_o   <= 1'b0;
         wb_addr_o <= '0;
         wb_data_o <= '0;
         rvalid_o  <= 1'b0;
         err_o     <= 1'b0;
         rdata_o   <= '0;
      end else begin
         cnt      <= (state_nxt != state || !bus_state) ? '0 : cnt_inc;
         wb_cyc_o <= cyc_nxt;
         wb_stb_o <= cyc_nxt;
         wb_we_o  <= we_nxt;
         rvalid_o <= (state_nxt == ST_RESP);
         err_o    <= 1'b0;
         if (req_i && gnt_o) begin
            wb_addr_o <= {addr_i[31:2], 2'b00};
            wb_data_o <= wdata_i;
            be_q      <= be_i;
         end
         if (state == ST_RMW_RD && ack) begin
            wb_data_o <= be_merge(wb_data_o, wb_data_i, be_q);
         end
         if (state_nxt == ST_RESP) begin
            err_o <= expire;
            if (expire)                    rdata_o <= ERR_RDATA;
            else if (state == ST_RD && ack) rdata_o <= wb_data_i;
            else                           rdata_o <= '0;
         end
      end
   end

endmodule
